// File: rtl/writeback_queue_if.sv
// Result-in / register-file-write-out bundle for writeback_queue.
// The queue sits on the slave modport. The producer and register file sit on the master side.
interface writeback_queue_if #(
  parameter int DATA_W = 8,
  parameter int REG_AW = 3
);
  logic              res_valid;
  logic              res_ready;
  logic [REG_AW-1:0] res_reg;
  logic [DATA_W-1:0] res_data;
  logic [REG_AW-1:0] dest_reg;
  logic [DATA_W-1:0] data;
  logic              write_flag;

  modport master (
    output res_valid, res_reg, res_data,
    input  res_ready, dest_reg, data, write_flag
  );

  modport slave (
    input  res_valid, res_reg, res_data,
    output res_ready, dest_reg, data, write_flag
  );
endinterface

// File: rtl/writeback_queue.sv
// Buffers execute/memory results and issues at most one register-file write per cycle.
// It also tracks the queued and in-flight writes to each register, so that issue logic can detect RAW hazards.
module writeback_queue #(
  parameter int DATA_W = 8,
  parameter int REG_AW = 3,
  parameter int DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  writeback_queue_if.slave            bus,
  input  logic                        stall,
  input  logic                        flush,
  output logic [(2**REG_AW)-1:0]      pending,
  output logic [$clog2(DEPTH+1)-1:0]  queue_count
);
  localparam int unsigned NREG = 2**REG_AW;
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH+2);
  localparam int AW = $clog2(DEPTH);

  logic [REG_AW-1:0] fifo_reg  [DEPTH];
  logic [DATA_W-1:0] fifo_data [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic [PW-1:0]     pend_cnt [NREG];
  logic              push, pop;

  // Readiness is based only on the current occupancy, so a full queue stays not-ready even during a pop cycle.
  assign bus.res_ready = rst_n && !flush && (count != CW'(DEPTH));
  assign push          = bus.res_valid && bus.res_ready;
  assign pop           = !stall && !flush && (count != '0);
  assign queue_count   = count;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_reg[wr_ptr]  <= bus.res_reg;
      fifo_data[wr_ptr] <= bus.res_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Output stage: destination register and data keep their last values while write_flag is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.write_flag <= 1'b0;
      bus.dest_reg   <= '0;
      bus.data       <= '0;
    end else begin
      bus.write_flag <= pop;
      if (pop) begin
        bus.dest_reg <= fifo_reg[rd_ptr];
        bus.data     <= fifo_data[rd_ptr];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NREG; r++) pend_cnt[r] <= '0;
    end else if (flush) begin
      for (int unsigned r = 0; r < NREG; r++) pend_cnt[r] <= '0;
    end else begin
      for (int unsigned r = 0; r < NREG; r++) begin
        if (push && (bus.res_reg == REG_AW'(r)) &&
            !(bus.write_flag && (bus.dest_reg == REG_AW'(r))))
          pend_cnt[r] <= pend_cnt[r] + PW'(1);
        else if (bus.write_flag && (bus.dest_reg == REG_AW'(r)) &&
                 !(push && (bus.res_reg == REG_AW'(r))))
          pend_cnt[r] <= pend_cnt[r] - PW'(1);
      end
    end
  end

  always_comb begin
    pending = '0;
    for (int unsigned r = 0; r < NREG; r++) pending[r] = (pend_cnt[r] != '0);
  end
endmodule

// File: tb/tb_writeback_queue.sv
// Directed test for writeback_queue. Stimulus queues expected writes, and a negedge monitor checks every write that leaves the queue.
module tb_writeback_queue;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       stall = 1'b0;
  logic       flush = 1'b0;
  logic [7:0] pending;
  logic [2:0] queue_count;

  int tests = 0;
  int fails = 0;
  logic [10:0] sb[$];
  logic [7:0]  rf[8];

  writeback_queue_if #(.DATA_W(8), .REG_AW(3)) bus ();

  writeback_queue #(.DATA_W(8), .REG_AW(3), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .stall(stall), .flush(flush),
    .pending(pending), .queue_count(queue_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares each register-file write with the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && bus.write_flag) begin
      if (sb.size() == 0) begin
        check("unexpected_write", {1'b1, bus.dest_reg, bus.data}, 12'h0);
      end else begin
        logic [10:0] e;
        e = sb.pop_front();
        check("write_reg", {29'd0, bus.dest_reg}, {29'd0, e[10:8]});
        check("write_data", {24'd0, bus.data}, {24'd0, e[7:0]});
        rf[bus.dest_reg] = bus.data;
      end
    end
  end

  // Drives one cycle from posedge+1 and returns at the next posedge+1.
  task automatic cycle(input logic v, input logic [2:0] r, input logic [7:0] d,
                       input logic st, input logic fl, input logic exp_acc);
    bus.res_valid = v;
    bus.res_reg   = r;
    bus.res_data  = d;
    stall = st;
    flush = fl;
    @(negedge clk);
    if (v) begin
      check("res_ready", {31'd0, bus.res_ready}, {31'd0, exp_acc});
      if (exp_acc) sb.push_back({r, d});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic st);
    cycle(1'b0, 3'd0, 8'd0, st, 1'b0, 1'b0);
  endtask

  initial begin
    bus.res_valid = 1'b0;
    bus.res_reg   = '0;
    bus.res_data  = '0;
    for (int i = 0; i < 8; i++) rf[i] = 8'h00;
    #1;
    check("reset_ready", {31'd0, bus.res_ready}, 32'd0);
    check("reset_wf", {31'd0, bus.write_flag}, 32'd0);
    check("reset_count", {29'd0, queue_count}, 32'd0);
    check("reset_pending", {24'd0, pending}, 32'd0);
    check("reset_dest", {29'd0, bus.dest_reg}, 32'd0);
    check("reset_data", {24'd0, bus.data}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: reset while one write is on the output stage and three writes are queued.
    cycle(1'b1, 3'd1, 8'h10, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 3'd2, 8'h20, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 3'd3, 8'h30, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 3'd4, 8'h40, 1'b1, 1'b0, 1'b1);
    idle(1'b0);
    check("t1_wf_before", {31'd0, bus.write_flag}, 32'd1);
    check("t1_count_before", {29'd0, queue_count}, 32'd3);
    check("t1_pending_before", {24'd0, pending}, 32'h1E);
    rst_n = 1'b0;
    #1;
    check("t1_wf", {31'd0, bus.write_flag}, 32'd0);
    check("t1_count", {29'd0, queue_count}, 32'd0);
    check("t1_pending", {24'd0, pending}, 32'd0);
    check("t1_ready", {31'd0, bus.res_ready}, 32'd0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1'b0);

    // 2: single write with two-edge latency.
    cycle(1'b1, 3'd3, 8'hA5, 1'b0, 1'b0, 1'b1);
    check("t2_pend_n", {24'd0, pending}, 32'h08);
    check("t2_wf_n", {31'd0, bus.write_flag}, 32'd0);
    check("t2_count_n", {29'd0, queue_count}, 32'd1);
    idle(1'b0);
    check("t2_wf_n1", {31'd0, bus.write_flag}, 32'd1);
    check("t2_dest_n1", {29'd0, bus.dest_reg}, 32'd3);
    check("t2_data_n1", {24'd0, bus.data}, 32'hA5);
    check("t2_pend_n1", {24'd0, pending}, 32'h08);
    idle(1'b0);
    check("t2_wf_n2", {31'd0, bus.write_flag}, 32'd0);
    check("t2_pend_n2", {24'd0, pending}, 32'd0);
    check("t2_data_hold", {24'd0, bus.data}, 32'hA5);

    // 3: fill the queue under stall, then drain it in order.
    for (int i = 1; i <= 4; i++)
      cycle(1'b1, 3'(i), 8'(i * 'h11), 1'b1, 1'b0, 1'b1);
    check("t3_count_full", {29'd0, queue_count}, 32'd4);
    cycle(1'b1, 3'd5, 8'h55, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 3'd5, 8'h55, 1'b1, 1'b0, 1'b0);
    check("t3_pending_full", {24'd0, pending}, 32'h1E);
    for (int i = 1; i <= 4; i++) begin
      idle(1'b0);
      check("t3_wf_drain", {31'd0, bus.write_flag}, 32'd1);
      check("t3_dest_drain", {29'd0, bus.dest_reg}, i);
    end
    idle(1'b0);
    check("t3_wf_end", {31'd0, bus.write_flag}, 32'd0);
    check("t3_ready_end", {31'd0, bus.res_ready}, 32'd1);
    check("t3_count_end", {29'd0, queue_count}, 32'd0);

    // 4: two writes to the same register. The pending bit must stay set until the second write completes.
    cycle(1'b1, 3'd5, 8'h01, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 3'd5, 8'h02, 1'b1, 1'b0, 1'b1);
    check("t4_pend_q", {24'd0, pending}, 32'h20);
    idle(1'b0);
    check("t4_pend_w1", {24'd0, pending}, 32'h20);
    idle(1'b0);
    check("t4_pend_w2", {24'd0, pending}, 32'h20);
    idle(1'b0);
    check("t4_pend_done", {24'd0, pending}, 32'd0);
    check("t4_rf5", {24'd0, rf[5]}, 32'h02);

    // 5: flush three queued writes. An accept attempted during the flush cycle must be refused.
    cycle(1'b1, 3'd0, 8'hC0, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 3'd6, 8'hC6, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 3'd7, 8'hC7, 1'b1, 1'b0, 1'b1);
    check("t5_pend_q", {24'd0, pending}, 32'hC1);
    check("t5_count_q", {29'd0, queue_count}, 32'd3);
    cycle(1'b1, 3'd2, 8'hEE, 1'b1, 1'b1, 1'b0);
    sb.delete();
    check("t5_count", {29'd0, queue_count}, 32'd0);
    check("t5_pending", {24'd0, pending}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      idle(1'b0);
      check("t5_no_write", {31'd0, bus.write_flag}, 32'd0);
    end

    // 6: back-to-back stream with no stall.
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 3'(i % 8), 8'(8'h60 + i), 1'b0, 1'b0, 1'b1);
      check("t6_count_le1", {31'd0, (queue_count <= 3'd1)}, 32'd1);
      if (i > 0) check("t6_wf", {31'd0, bus.write_flag}, 32'd1);
    end
    idle(1'b0);
    check("t6_last_dest", {29'd0, bus.dest_reg}, 32'd1);
    check("t6_last_data", {24'd0, bus.data}, 32'h69);
    idle(1'b0);
    idle(1'b0);
    check("sb_drained", sb.size(), 32'd0);
    check("final_pending", {24'd0, pending}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
